// File: rtl/k12a_spi_target_if.sv
// Signal bundle between the K12a SPI target port, the external SPI controller and the CPU I/O decoder.
// The slave modport is the target's view; the master modport drives the target's inputs.
interface k12a_spi_target_if;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       selected;
  logic       byte_done;

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, tx_data, tx_write, rx_ack,
    output spi_miso, spi_miso_oe, tx_full, rx_data, rx_valid, rx_overrun, selected, byte_done
  );

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, tx_data, tx_write, rx_ack,
    input  spi_miso, spi_miso_oe, tx_full, rx_data, rx_valid, rx_overrun, selected, byte_done
  );
endinterface

// File: rtl/k12a_spi_target.sv
// SPI mode-0 target, MSB first, 8-bit frames, oversampled in the cpu_clock domain.
// One-byte RX holding register with overrun flag and one-byte TX buffer with idle fill of 8'hFF.
module k12a_spi_target (
  input  logic               cpu_clock,
  input  logic               reset,
  k12a_spi_target_if.slave   bus
);

  logic [2:0] sck_q, cs_q;
  logic [1:0] mosi_q;
  logic [6:0] shift_in_q, shift_in_d;
  logic [7:0] shift_out_q, shift_out_d;
  logic [2:0] bit_count_q, bit_count_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic       byte_done_q, byte_done_d;

  logic sck_rise, sck_fall, cs_fall, cs_rise, sel, mosi_s;
  logic consume, done;

  // Stage 1-2 synchronize; stage 3 of sck and cs_n is the previous sample for edge detection.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      sck_q  <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], bus.spi_sck};
      cs_q   <= {cs_q[1:0], bus.spi_cs_n};
      mosi_q <= {mosi_q[0], bus.spi_mosi};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign sel      = ~cs_q[1];
  assign mosi_s   = mosi_q[1];

  always_comb begin
    shift_in_d   = shift_in_q;
    shift_out_d  = shift_out_q;
    bit_count_d  = bit_count_q;
    tx_buf_d     = tx_buf_q;
    tx_full_d    = tx_full_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    byte_done_d  = 1'b0;
    consume      = 1'b0;
    done         = 1'b0;

    if (cs_fall) begin
      bit_count_d = 3'd0;
      consume     = 1'b1;
    end else if (cs_rise) begin
      bit_count_d = 3'd0;
    end else if (sel) begin
      if (sck_rise) begin
        shift_in_d  = {shift_in_q[5:0], mosi_s};
        bit_count_d = bit_count_q + 3'd1;
        if (bit_count_q == 3'd7) begin
          rx_data_d   = {shift_in_q, mosi_s};
          rx_valid_d  = 1'b1;
          byte_done_d = 1'b1;
          done        = 1'b1;
        end
      end else if (sck_fall) begin
        if (bit_count_q == 3'd0) consume = 1'b1;
        else shift_out_d = {shift_out_q[6:0], 1'b1};
      end
    end

    // Reload at a byte boundary uses the buffer contents from before any same-cycle write.
    if (consume) begin
      shift_out_d = tx_full_q ? tx_buf_q : 8'hFF;
      tx_full_d   = 1'b0;
    end
    if (bus.tx_write) begin
      tx_buf_d  = bus.tx_data;
      tx_full_d = 1'b1;
    end

    if (done) begin
      rx_overrun_d = bus.rx_ack ? 1'b0 : (rx_overrun_q | rx_valid_q);
    end else if (bus.rx_ack) begin
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      shift_in_q   <= 7'd0;
      shift_out_q  <= 8'hFF;
      bit_count_q  <= 3'd0;
      tx_buf_q     <= 8'd0;
      tx_full_q    <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      byte_done_q  <= 1'b0;
    end else begin
      shift_in_q   <= shift_in_d;
      shift_out_q  <= shift_out_d;
      bit_count_q  <= bit_count_d;
      tx_buf_q     <= tx_buf_d;
      tx_full_q    <= tx_full_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      byte_done_q  <= byte_done_d;
    end
  end

  assign bus.spi_miso    = sel ? shift_out_q[7] : 1'b1;
  assign bus.spi_miso_oe = sel;
  assign bus.selected    = sel;
  assign bus.tx_full     = tx_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overrun  = rx_overrun_q;
  assign bus.byte_done   = byte_done_q;

endmodule

// File: tb/tb_k12a_spi_target.sv
// Directed bench for k12a_spi_target: a table of single-frame vectors plus hand-written
// sequences for back-to-back frames, aborted frames, ack/completion collision and mid-frame reset.
module tb_k12a_spi_target;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   bd_cnt = 0;

  k12a_spi_target_if bus();

  k12a_spi_target dut (
    .cpu_clock (clk),
    .reset     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.byte_done === 1'b1) bd_cnt <= bd_cnt + 1;

  typedef struct {
    logic       wr;
    logic [7:0] tx;
    logic       pre_ack;
    logic [7:0] mosi;
    logic [7:0] e_miso;
    logic [7:0] e_rx;
    logic       e_valid;
    logic       e_ovr;
    logic       e_full;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tx_wr(input logic [7:0] b);
    bus.tx_data  = b;
    bus.tx_write = 1'b1;
    @(negedge clk);
    bus.tx_write = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_high();
    bus.spi_cs_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Controller side of one frame: MOSI set in the low phase, MISO sampled as SCK rises.
  task automatic xfer(input logic [7:0] mosi_b, input int nbits, input bit ack_last,
                      input bit mid_wr, input logic [7:0] mid_b, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.spi_mosi = mosi_b[i];
      repeat (5) @(negedge clk);
      miso_b[i]   = bus.spi_miso;
      bus.spi_sck = 1'b1;
      for (int c = 0; c < 5; c++) begin
        bus.rx_ack   = (i == 0 && ack_last && c == 2);
        bus.tx_write = (i == 0 && mid_wr && c == 0);
        bus.tx_data  = mid_b;
        @(negedge clk);
      end
      bus.rx_ack   = 1'b0;
      bus.tx_write = 1'b0;
      bus.spi_sck  = 1'b0;
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [7:0] m;
    int bd0;

    vecs[0] = '{wr:1, tx:8'hA5, pre_ack:1, mosi:8'h3C, e_miso:8'hA5, e_rx:8'h3C, e_valid:1, e_ovr:0, e_full:0};
    vecs[1] = '{wr:0, tx:8'h00, pre_ack:1, mosi:8'h81, e_miso:8'hFF, e_rx:8'h81, e_valid:1, e_ovr:0, e_full:0};
    vecs[2] = '{wr:1, tx:8'h5A, pre_ack:0, mosi:8'hE7, e_miso:8'h5A, e_rx:8'hE7, e_valid:1, e_ovr:1, e_full:0};
    vecs[3] = '{wr:0, tx:8'h00, pre_ack:1, mosi:8'h00, e_miso:8'hFF, e_rx:8'h00, e_valid:1, e_ovr:0, e_full:0};
    vecs[4] = '{wr:1, tx:8'h00, pre_ack:1, mosi:8'hFF, e_miso:8'h00, e_rx:8'hFF, e_valid:1, e_ovr:0, e_full:0};

    rst = 1'b1;
    bus.spi_sck = 1'b0; bus.spi_cs_n = 1'b1; bus.spi_mosi = 1'b0;
    bus.tx_data = 8'h00; bus.tx_write = 1'b0; bus.rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", bus.spi_miso, 1);
    chk("rst_oe", bus.spi_miso_oe, 0);
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_full", bus.tx_full, 0);
    chk("rst_ovr", bus.rx_overrun, 0);
    chk("rst_sel", bus.selected, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].wr) tx_wr(vecs[v].tx);
      if (vecs[v].wr) chk($sformatf("v%0d_full_pre", v), bus.tx_full, 1);
      if (vecs[v].pre_ack) ack_pulse();
      bd0 = bd_cnt;
      cs_low();
      chk($sformatf("v%0d_sel", v), {bus.selected, bus.spi_miso_oe}, 2'b11);
      xfer(vecs[v].mosi, 8, 0, 0, 8'h00, m);
      cs_high();
      chk($sformatf("v%0d_miso", v), m, vecs[v].e_miso);
      chk($sformatf("v%0d_rx", v), bus.rx_data, vecs[v].e_rx);
      chk($sformatf("v%0d_valid", v), bus.rx_valid, vecs[v].e_valid);
      chk($sformatf("v%0d_ovr", v), bus.rx_overrun, vecs[v].e_ovr);
      chk($sformatf("v%0d_full", v), bus.tx_full, vecs[v].e_full);
      chk($sformatf("v%0d_bd", v), bd_cnt - bd0, 1);
      chk($sformatf("v%0d_idle_miso", v), bus.spi_miso, 1);
    end

    // Back-to-back frames with CS held low; second TX byte written during the first frame's last bit.
    ack_pulse();
    tx_wr(8'h12);
    cs_low();
    xfer(8'h11, 8, 0, 1, 8'h34, m);
    chk("b2b_miso1", m, 8'h12);
    chk("b2b_rx1", bus.rx_data, 8'h11);
    chk("b2b_ovr1", bus.rx_overrun, 0);
    xfer(8'h22, 8, 0, 0, 8'h00, m);
    chk("b2b_miso2", m, 8'h34);
    cs_high();
    chk("b2b_rx2", bus.rx_data, 8'h22);
    chk("b2b_valid", bus.rx_valid, 1);
    chk("b2b_ovr2", bus.rx_overrun, 1);
    chk("b2b_full", bus.tx_full, 0);

    // Aborted frame after 5 bits, then a full frame.
    ack_pulse();
    chk("ack_clr", {bus.rx_valid, bus.rx_overrun}, 2'b00);
    bd0 = bd_cnt;
    cs_low();
    xfer(8'hAA, 5, 0, 0, 8'h00, m);
    cs_high();
    chk("abort_valid", bus.rx_valid, 0);
    cs_low();
    xfer(8'hC3, 8, 0, 0, 8'h00, m);
    cs_high();
    chk("abort_bd", bd_cnt - bd0, 1);
    chk("abort_rx", bus.rx_data, 8'hC3);

    // Ack coincides with completion while rx_valid is already set.
    cs_low();
    xfer(8'h6B, 8, 1, 0, 8'h00, m);
    cs_high();
    chk("ackcol_valid", bus.rx_valid, 1);
    chk("ackcol_ovr", bus.rx_overrun, 0);
    chk("ackcol_rx", bus.rx_data, 8'h6B);

    // Reset in the middle of a frame.
    tx_wr(8'h77);
    cs_low();
    xfer(8'h0F, 4, 0, 0, 8'h00, m);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_miso", bus.spi_miso, 1);
    chk("mrst_oe", bus.spi_miso_oe, 0);
    chk("mrst_sel", bus.selected, 0);
    chk("mrst_flags", {bus.rx_valid, bus.rx_overrun, bus.tx_full, bus.byte_done}, 4'b0000);
    chk("mrst_rx", bus.rx_data, 8'h00);
    bus.spi_cs_n = 1'b1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_sel", bus.selected, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
